// File: rtl/fpu_pkg.sv
// Shared single-precision field widths, constants and the divider FSM state type.
package fpu_pkg;

   localparam int unsigned EXP_W = 8;
   localparam int unsigned MAN_W = 23;
   localparam int unsigned BIAS  = 127;
   localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

   // 25 quotient bits plus one guard bit
   localparam int unsigned ITER  = 26;
   localparam int unsigned Q_W   = ITER;
   localparam int unsigned REM_W = MAN_W + 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } fdiv_state_t;

   function automatic logic [31:0] pack_fp(input logic s, input logic [EXP_W-1:0] e,
                                           input logic [MAN_W-1:0] m);
      return {s, e, m};
   endfunction

endpackage

// File: rtl/fdiv_mant.sv
// Iterative restoring radix-2 mantissa divider; the first quotient bit is
// produced on the start edge, the last one on the edge that raises done.
module fdiv_mant
   import fpu_pkg::*;
(
   input  logic             clk,
   input  logic             rstn,
   input  logic             start,
   input  logic [MAN_W:0]   m1ex,
   input  logic [MAN_W:0]   m2ex,
   output logic             done,
   output logic [Q_W-1:0]   q,
   output logic             sticky
);

   logic [REM_W-1:0] r_rem;
   logic [MAN_W:0]   r_div;
   logic [Q_W-1:0]   r_q;
   logic [4:0]       r_cnt;
   logic             r_busy;
   logic             r_done;
   logic             r_sticky;

   logic [REM_W-1:0] w_rem_cur;
   logic [REM_W-1:0] w_div_ext;
   logic             w_ge;
   logic [REM_W-1:0] w_diff;

   // On start the first step operates on the incoming operands directly
   assign w_rem_cur = start ? {2'b00, m1ex} : r_rem;
   assign w_div_ext = start ? {2'b00, m2ex} : {2'b00, r_div};
   assign w_ge      = (w_rem_cur >= w_div_ext);
   assign w_diff    = w_ge ? (w_rem_cur - w_div_ext) : w_rem_cur;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_rem    <= '0;
         r_div    <= '0;
         r_q      <= '0;
         r_cnt    <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_sticky <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (start) begin
            r_div  <= m2ex;
            r_rem  <= {w_diff[REM_W-2:0], 1'b0};
            r_q    <= Q_W'(w_ge);
            r_cnt  <= 5'd1;
            r_busy <= 1'b1;
         end else if (r_busy) begin
            r_rem <= {w_diff[REM_W-2:0], 1'b0};
            r_q   <= {r_q[Q_W-2:0], w_ge};
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == 5'(ITER - 1)) begin
               r_busy   <= 1'b0;
               r_done   <= 1'b1;
               r_sticky <= (w_diff != '0);
            end
         end
      end
   end

   assign done   = r_done;
   assign q      = r_q;
   assign sticky = r_sticky;

endmodule

// File: rtl/fdiv.sv
// Single-precision divider: handshake, special cases, exponent and packing.
// Optional FDIV_ROUND_EN selects round-to-nearest-even instead of truncation.
module fdiv
   import fpu_pkg::*;
(
   input  logic        clk,
   input  logic        rstn,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] x1,
   input  logic [31:0] x2,
   output logic [31:0] y,
   output logic        out_valid,
   input  logic        out_ready
);

   fdiv_state_t r_state, w_next;

   logic [31:0]      r_y;
   logic             r_sy;
   logic [EXP_W-1:0] r_e1;
   logic [EXP_W-1:0] r_e2;

   logic             w_accept;
   logic             w_x1_zero;
   logic             w_x2_zero;
   logic             w_special;
   logic             w_sy_in;
   logic [31:0]      w_special_y;
   logic             w_done;
   logic [Q_W-1:0]   w_q;
   logic             w_sticky;
   logic [MAN_W-1:0] w_man_t;
   logic             w_guard;
   logic signed [9:0] w_exp_base;
   logic signed [9:0] w_exp;
   logic [MAN_W-1:0] w_man;
   logic [31:0]      w_result;

   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == DONE);
   assign y         = r_y;

   assign w_accept    = in_valid && (r_state == IDLE);
   assign w_x1_zero   = (x1[30:23] == '0);
   assign w_x2_zero   = (x2[30:23] == '0);
   assign w_special   = w_x1_zero || w_x2_zero;
   assign w_sy_in     = x1[31] ^ x2[31];
   // Zero divisor wins, so 0/0 also yields infinity
   assign w_special_y = w_x2_zero ? pack_fp(w_sy_in, EXP_MAX, '0) : {w_sy_in, 31'b0};

   fdiv_mant u_mant (
      .clk    (clk),
      .rstn   (rstn),
      .start  (w_accept && !w_special),
      .m1ex   ({1'b1, x1[22:0]}),
      .m2ex   ({1'b1, x2[22:0]}),
      .done   (w_done),
      .q      (w_q),
      .sticky (w_sticky)
   );

   assign w_man_t    = w_q[Q_W-1] ? w_q[24:2] : w_q[23:1];
   assign w_guard    = w_q[Q_W-1] ? w_q[1]    : w_q[0];
   assign w_exp_base = $signed({2'b00, r_e1}) - $signed({2'b00, r_e2})
                     + $signed(w_q[Q_W-1] ? 10'(BIAS) : 10'(BIAS - 1));

`ifdef FDIV_ROUND_EN
   logic             w_round_up;
   logic [MAN_W:0]   w_man_sum;
   assign w_round_up = w_guard && (w_sticky || w_man_t[0]);
   assign w_man_sum  = {1'b0, w_man_t} + (MAN_W+1)'(w_round_up);
   // Mantissa overflow wraps to zero and bumps the exponent
   assign w_man      = w_man_sum[MAN_W-1:0];
   assign w_exp      = w_exp_base + $signed(10'(w_man_sum[MAN_W]));
`else
   logic             w_unused;
   assign w_unused   = w_guard ^ w_sticky;
   assign w_man      = w_man_t;
   assign w_exp      = w_exp_base;
`endif

   always_comb begin
      w_result = pack_fp(r_sy, w_exp[7:0], w_man);
      if (w_exp <= 10'sd0) begin
         w_result = {r_sy, 31'b0};
      end else if (w_exp >= 10'sd255) begin
         w_result = pack_fp(r_sy, EXP_MAX, '0);
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_next = w_special ? DONE : BUSY;
         BUSY:    if (w_done) w_next = DONE;
         DONE:    if (out_ready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_y  <= '0;
         r_sy <= 1'b0;
         r_e1 <= '0;
         r_e2 <= '0;
      end else begin
         if (w_accept) begin
            r_sy <= w_sy_in;
            r_e1 <= x1[30:23];
            r_e2 <= x2[30:23];
            if (w_special) r_y <= w_special_y;
         end
         if (r_state == BUSY && w_done) r_y <= w_result;
      end
   end

endmodule

// File: doc/fdiv.md
FDIV -- requirements
Module: fdiv

Interface
REQ-001 Parameters: none; all widths are fixed by the single-precision format.
REQ-002 clk  input  1  rising-edge clock, the only clock.
REQ-003 rstn  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  x1/x2 hold a valid operand pair.
REQ-005 in_ready  output  1  block accepts an operand pair this cycle.
REQ-006 x1  input  32  dividend, IEEE-754 single.
REQ-007 x2  input  32  divisor, IEEE-754 single.
REQ-008 y  output  32  quotient x1/x2, IEEE-754 single.
REQ-009 out_valid  output  1  y holds a valid result.
REQ-010 out_ready  input  1  consumer takes y this cycle.

Function
REQ-011 Accept SHALL occur only on an edge where in_valid=1 and in_ready=1; x1/x2 SHALL be latched on that edge.
REQ-012 FSM states SHALL be IDLE, BUSY and DONE; in_ready SHALL equal (state==IDLE); out_valid SHALL equal (state==DONE).
REQ-013 IDLE->BUSY on accept of a normal pair; IDLE->DONE on accept of a special pair; BUSY->DONE after the final iteration; DONE->IDLE on out_valid&&out_ready.
REQ-014 Sign SHALL be sy = x1[31]^x2[31] for every result, including specials.
REQ-015 An operand with exponent field 0 SHALL be treated as zero; denormals flush to zero.
REQ-016 Special case, x2 zero: y = {sy,8'hFF,23'b0}; this case has priority, so 0/0 also gives infinity.
REQ-017 Special case, x1 zero and x2 nonzero: y = {sy,31'b0}.
REQ-018 Exponent 255 inputs SHALL be treated as ordinary exponents; no NaN or Inf detection is performed.
REQ-019 Mantissas SHALL be m1ex={1,x1[22:0]} and m2ex={1,x2[22:0]}.
REQ-020 Division SHALL be restoring radix-2, one quotient bit per cycle, 26 iterations: 25 quotient bits plus 1 guard bit.
REQ-021 Remainder SHALL start as m1ex; each iteration sets q=(R>=m2ex), subtracts m2ex when q=1, then shifts R left by 1.
REQ-022 Sticky SHALL be (final R != 0).
REQ-023 Normalization when q[25]=1: mantissa=q[24:2], guard=q[1], exponent=e1-e2+127.
REQ-024 Normalization when q[25]=0: mantissa=q[23:1], guard=q[0], exponent=e1-e2+126.
REQ-025 Exponent SHALL be computed 10-bit signed; a result <=0 gives {sy,31'b0}; a result >=255 gives {sy,8'hFF,23'b0}.
REQ-026 Latency SHALL be 27 edges from the accept edge to out_valid=1 for normal pairs, and 1 edge for special pairs.
REQ-027 y and out_valid SHALL hold stable while out_valid=1 and out_ready=0.
REQ-028 No new operands SHALL be accepted while state is BUSY or DONE; there is no overlap of operations.

Reset
REQ-029 rstn=0 at an edge SHALL force state=IDLE, y=0 and out_valid=0; in_ready SHALL be 1 on the first edge after release.
REQ-030 Reset during BUSY or DONE SHALL abandon the operation silently; no result is produced.

Configuration
REQ-031 Macro FDIV_ROUND_EN defined: round-to-nearest-even from the guard bit, sticky and mantissa LSB; a mantissa carry-out SHALL increment the exponent before the REQ-025 clamp.
REQ-032 FDIV_ROUND_EN undefined: the result SHALL be truncated, guard and sticky ignored; latency is identical in both builds.

Structure
REQ-033 Shared package fpu_pkg SHALL hold the field widths (EXP_W=8, MAN_W=23), BIAS=127, EXP_MAX=8'hFF and the FSM state typedef.
REQ-034 One sub-module SHALL be used: fdiv_mant, the iterative mantissa divider with start/done signals, outputting q[25:0] and sticky; fdiv owns the handshake, specials, exponent and packing.

Verification
REQ-035 6.0/2.0: 0x40C00000 / 0x40000000 -> y=0x40400000, out_valid exactly 27 edges after accept.
REQ-036 1.0/3.0: 0x3F800000 / 0x40400000 -> y=0x3EAAAAAA without FDIV_ROUND_EN, y=0x3EAAAAAB with it.
REQ-037 Divide by zero: 0x3F800000 / 0x80000000 -> y=0xFF800000, 1-edge latency; 0/0 (0x00000000 / 0x00000000) -> y=0x7F800000.
REQ-038 Underflow: 0x00800000 / 0x7F000000 -> y=0x00000000; 0x00000000 / 0x3F800000 -> y=0x00000000.
REQ-039 Backpressure: hold out_ready=0 for 5 cycles after out_valid -> y stable, in_ready=0, in_valid ignored; the next op is accepted only after the out_valid&&out_ready handshake.
REQ-040 Reset mid-BUSY (10 edges after accept) -> out_valid=0, y=0, in_ready=1 after release; the following 6.0/2.0 produces 0x40400000.
